// File: rtl/cordic_atanh_iter_if.sv
// cordic_atanh_iter_if
//   Handshake bundle for the atanh CORDIC core.
//   master : operand producer / result consumer (drives in_valid, in_t, out_ready)
//   slave  : the CORDIC core (drives in_ready, out_valid, out_z, out_ovf)
//   in_valid/in_ready/in_t     : operand t, signed Q3.12
//   out_valid/out_ready/out_z  : result, signed Q3.12, saturated
//   out_ovf                    : operand was out of range, out_z saturated
interface cordic_atanh_iter_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_t;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_z;
  logic               out_ovf;

  modport master (
    output in_valid, in_t, out_ready,
    input  in_ready, out_valid, out_z, out_ovf
  );

  modport slave (
    input  in_valid, in_t, out_ready,
    output in_ready, out_valid, out_z, out_ovf
  );
endinterface

// File: rtl/cordic_atanh_iter.sv
// cordic_atanh_iter
//   Iterative hyperbolic-vectoring CORDIC computing z = atanh(t), one operand
//   in flight, one micro-rotation per clock (indices 1..ITERS, 4 and 13 done
//   twice). Operands with |t| > TLIM skip the iterations and return a
//   saturated result with out_ovf set.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cordic_atanh_iter_if.slave (in_valid/in_ready/in_t,
//          out_valid/out_ready/out_z/out_ovf)
// Configuration
//   LOGIT_MODE_EN : input is a probability p; t = 2p - 1 and the result is
//                   2*atanh(t) = logit(p). Undefined: plain atanh.
module cordic_atanh_iter #(
  parameter int ITERS = 14,
  parameter int IW    = 20,
  parameter int TLIM  = 3302
) (
  input logic                clk,
  input logic                rst,
  cordic_atanh_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic signed [17:0]   TLIM_P = 18'(TLIM);
  localparam logic signed [17:0]   TLIM_N = -18'(TLIM);
  localparam logic signed [IW-1:0] X_ONE  = IW'(1 << 16);
  localparam logic signed [IW+1:0] Z_MAX  = (IW+2)'(32767);
  localparam logic signed [IW+1:0] Z_MIN  = (IW+2)'(-32768);
  localparam logic signed [IW+1:0] Z_HALF = (IW+2)'(8);

  state_t                state_reg;
  logic signed [IW-1:0]  x_reg, y_reg, z_reg;
  logic [4:0]            i_reg;
  logic                  rep_reg;
  logic                  in_ready_reg, out_valid_reg, out_ovf_reg;
  logic signed [15:0]    out_z_reg;

  // round(atanh(2^-i) * 2^16)
  function automatic logic signed [IW-1:0] atanh_rom(input logic [4:0] idx);
    case (idx)
      5'd1:    atanh_rom = IW'(35999);
      5'd2:    atanh_rom = IW'(16739);
      5'd3:    atanh_rom = IW'(8235);
      5'd4:    atanh_rom = IW'(4101);
      5'd5:    atanh_rom = IW'(2049);
      5'd6:    atanh_rom = IW'(1024);
      5'd7:    atanh_rom = IW'(512);
      5'd8:    atanh_rom = IW'(256);
      5'd9:    atanh_rom = IW'(128);
      5'd10:   atanh_rom = IW'(64);
      5'd11:   atanh_rom = IW'(32);
      5'd12:   atanh_rom = IW'(16);
      5'd13:   atanh_rom = IW'(8);
      5'd14:   atanh_rom = IW'(4);
      5'd15:   atanh_rom = IW'(2);
      5'd16:   atanh_rom = IW'(1);
      default: atanh_rom = '0;
    endcase
  endfunction

  // Operand pre-processing: t in Q3.12 widened to 18 bits so 2p-1 cannot wrap.
  logic signed [17:0]    t_ext;
  logic                  t_ovf;
  logic signed [IW-1:0]  y_ext, y_load;

  always_comb begin
`ifdef LOGIT_MODE_EN
    t_ext = $signed({bus.in_t[15], bus.in_t, 1'b0}) - 18'sd4096;
`else
    t_ext = {{2{bus.in_t[15]}}, bus.in_t};
`endif
    t_ovf  = (t_ext > TLIM_P) || (t_ext < TLIM_N);
    y_ext  = {{(IW-18){t_ext[17]}}, t_ext};
    y_load = y_ext <<< 4;   // Q3.12 -> Q3.16
  end

  // One micro-rotation. d = +1 when y < 0, which drives y toward zero.
  logic signed [IW-1:0]  x_sh, y_sh, x_next, y_next, z_next, ang;
  logic                  rep_pending, last_step;
  logic signed [IW+1:0]  z_scaled, z_rnd;
  logic signed [15:0]    z_sat;

  always_comb begin
    x_sh = x_reg >>> i_reg;
    y_sh = y_reg >>> i_reg;
    ang  = atanh_rom(i_reg);
    if (y_reg[IW-1]) begin
      x_next = x_reg + y_sh;
      y_next = y_reg + x_sh;
      z_next = z_reg - ang;
    end else begin
      x_next = x_reg - y_sh;
      y_next = y_reg - x_sh;
      z_next = z_reg + ang;
    end
    rep_pending = ((i_reg == 5'd4) || (i_reg == 5'd13)) && !rep_reg;
    last_step   = (i_reg == 5'(ITERS)) && !rep_pending;

`ifdef LOGIT_MODE_EN
    z_scaled = {z_next[IW-1], z_next, 1'b0};          // 2*atanh(t)
`else
    z_scaled = {{2{z_next[IW-1]}}, z_next};
`endif
    // Q3.16 -> Q3.12 with round-half-up, then clamp to 16 bits.
    z_rnd = (z_scaled + Z_HALF) >>> 4;
    if (z_rnd > Z_MAX)
      z_sat = 16'sh7FFF;
    else if (z_rnd < Z_MIN)
      z_sat = 16'sh8000;
    else
      z_sat = z_rnd[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_z_reg     <= '0;
      out_ovf_reg   <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      i_reg         <= '0;
      rep_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            if (t_ovf) begin
              out_z_reg     <= (t_ext > 18'sd0) ? 16'sh7FFF : 16'sh8001;
              out_ovf_reg   <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              x_reg     <= X_ONE;
              y_reg     <= y_load;
              z_reg     <= '0;
              i_reg     <= 5'd1;
              rep_reg   <= 1'b0;
              state_reg <= ITER;
            end
          end
        end
        ITER: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (rep_pending) begin
            rep_reg <= 1'b1;
          end else begin
            rep_reg <= 1'b0;
            i_reg   <= i_reg + 5'd1;
          end
          if (last_step) begin
            out_z_reg     <= z_sat;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_z     = out_z_reg;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_cordic_atanh_iter.sv
// tb_cordic_atanh_iter
//   Drives directed and random operands into cordic_atanh_iter and compares
//   each result with a real-arithmetic atanh reference.
module tb_cordic_atanh_iter;
  localparam int ITERS = 14;
  localparam int TLIM  = 3302;
  localparam int STEPS = ITERS + ((ITERS >= 4) ? 1 : 0) + ((ITERS >= 13) ? 1 : 0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  cordic_atanh_iter_if bus();

  cordic_atanh_iter #(.ITERS(ITERS), .IW(20), .TLIM(TLIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fails++;
      $display("FAIL %s: got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Reference: t derived from the input, range check, then atanh in real arithmetic.
  function automatic void model(input int t_in, output int z, output int ovf);
    int  t;
    real r;
`ifdef LOGIT_MODE_EN
    t = 2 * t_in - 4096;
`else
    t = t_in;
`endif
    if (t > TLIM || t < -TLIM) begin
      ovf = 1;
      z   = (t > 0) ? 32767 : -32767;
    end else begin
      ovf = 0;
      r   = 0.5 * $ln((1.0 + t / 4096.0) / (1.0 - t / 4096.0)) * 4096.0;
`ifdef LOGIT_MODE_EN
      r   = 2.0 * r;
`endif
      z   = $rtoi($floor(r + 0.5));
    end
  endfunction

  // One transaction: present t, count edges (accept edge = 1) until out_valid,
  // optionally hold out_ready low for 'hold' cycles with a pending in_valid.
  task automatic do_op(input int t, input int hold, output int z, output int ovf, output int lat);
    int z0;
    check("in_ready_before_op", int'(bus.in_ready), 1, 0);
    bus.in_valid = 1'b1;
    bus.in_t     = 16'(t);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (lat == 2) check("in_ready_iter", int'(bus.in_ready), 0, 0);
      @(negedge clk);
      lat++;
    end
    z   = int'(bus.out_z);
    ovf = int'(bus.out_ovf);
    z0  = z;
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_t     = 16'sd3000;
      @(negedge clk);
      check("bp_out_z_stable", int'(bus.out_z), z0, 0);
      check("bp_in_ready_low", int'(bus.in_ready), 0, 0);
      check("bp_out_valid_held", int'(bus.out_valid), 1, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", int'(bus.out_valid), 0, 0);
    check("in_ready_return", int'(bus.in_ready), 1, 0);
  endtask

  // Run an operand and compare result, overflow flag and latency with the model.
  task automatic run_and_check(input string tag, input int t, input int tol, input int hold, output int z);
    int ez, eovf, ovf, lat;
    model(t, ez, eovf);
    do_op(t, hold, z, ovf, lat);
    $display("op %s t=%0d z=%0d exp=%0d ovf=%0d lat=%0d", tag, t, z, ez, ovf, lat);
    check({tag, "_z"}, z, ez, eovf ? 0 : tol);
    check({tag, "_ovf"}, ovf, eovf, 0);
    check({tag, "_lat"}, lat, eovf ? 1 : STEPS + 1, 0);
  endtask

  initial begin
    int z, zn, seen, t;
    bus.in_valid  = 1'b0;
    bus.in_t      = '0;
    bus.out_ready = 1'b0;

    // Reset held for two edges.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0, 0);
    check("rst_out_z", int'(bus.out_z), 0, 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1, 0);

    // Directed values, including the range boundaries.
    run_and_check("half_pos", 2048, 2, 0, z);
    check("half_pos_abs", z, 2250, 2);
    run_and_check("half_neg", -2048, 2, 0, z);
    check("half_neg_abs", z, -2250, 2);
    run_and_check("zero", 0, 0, 0, z);
    run_and_check("ovf_pos", 3686, 0, 0, z);
    check("ovf_pos_abs", z, 32767, 0);
    run_and_check("ovf_neg", -3686, 0, 0, z);
    check("ovf_neg_abs", z, -32767, 0);
    run_and_check("tlim_pos", TLIM, 3, 0, z);
    run_and_check("tlim_neg", -TLIM, 3, 0, zn);
    check("tlim_sym", zn, -z, 1);
    run_and_check("tlim1_pos", TLIM + 1, 0, 0, z);
    run_and_check("tlim1_neg", -(TLIM + 1), 0, 0, z);

    // Back-pressure with a pending operand, then a fresh operand.
    run_and_check("bp", 1500, 3, 5, z);
    run_and_check("after_bp", -700, 3, 0, z);

    // Reset in the middle of the iterations aborts the operand.
    bus.in_valid = 1'b1;
    bus.in_t     = 16'sd1000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_out_valid", seen, 0, 0);
    run_and_check("after_abort", 1024, 2, 0, z);
    check("after_abort_abs", z, 1046, 2);

    // Random operands in +/- pairs, covering both sides of the range limit.
    for (int n = 0; n < 15; n++) begin
      t = int'($urandom_range(3500, 1));
      run_and_check("rnd_pos", t, 3, int'($urandom_range(2, 0)), z);
      run_and_check("rnd_neg", -t, 3, 0, zn);
      check("rnd_sym", zn, (t > TLIM) ? -32767 : -z, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
